// File: rtl/achannel_to_rtsnoc_tx.sv
// RMI transmit path: captures one message from an HLS output ac_channel and
// serializes it into RTSNoC flits on the router local write port.
//
// Ports:
//   clk_i, rst_n_i : clock (rising edge), async active-low reset
//   tx_ch_z_i      : message from node output channel
//   tx_ch_lz_i     : node write strobe (message valid this cycle)
//   tx_ch_vz_o     : channel can accept a message
//   din_o, wr_o    : flit to router and its write request
//   wait_i         : router back-pressure, flit not taken while high
//   busy_o         : message in flight
//   err_o          : sticky, write strobe seen while not ready
//   msg_cnt_o      : messages fully sent, wraps
module achannel_to_rtsnoc_tx #(
   parameter int                SIZE_X       = 1,
   parameter int                SIZE_Y       = 1,
   parameter logic [SIZE_X-1:0] X            = 1'b1,
   parameter logic [SIZE_Y-1:0] Y            = 1'b1,
   parameter logic [2:0]        LOCAL_ADDR   = 3'b101,
   parameter int                SIZE_DATA    = 56,
   parameter int                RMI_MSG_SIZE = 80,
   parameter int                CNT_W        = 16,
   localparam int BUS_SIZE = SIZE_DATA + 2*SIZE_X + 2*SIZE_Y + 6
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [RMI_MSG_SIZE-1:0] tx_ch_z_i,
   input  logic                    tx_ch_lz_i,
   output logic                    tx_ch_vz_o,
   output logic [BUS_SIZE-1:0]     din_o,
   output logic                    wr_o,
   input  logic                    wait_i,
   output logic                    busy_o,
   output logic                    err_o,
   output logic [CNT_W-1:0]        msg_cnt_o
);

   localparam int N_FLITS = (RMI_MSG_SIZE + SIZE_DATA - 1) / SIZE_DATA;
   localparam int IDX_W   = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
   localparam int PAD_W   = N_FLITS * SIZE_DATA;
   localparam int HDR_W   = SIZE_X + SIZE_Y + 3;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FLITS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [RMI_MSG_SIZE-1:0] msg_q, msg_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    err_q, err_d;

   logic [PAD_W-1:0]        padded;
   logic [SIZE_DATA-1:0]    data;
   logic [HDR_W-1:0]        dst;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         msg_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         msg_q   <= msg_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      msg_d      = msg_q;
      cnt_d      = cnt_q;
      tx_ch_vz_o = 1'b0;
      wr_o       = 1'b0;
      busy_o     = 1'b0;
      unique case (state_q)
         IDLE: begin
            tx_ch_vz_o = 1'b1;
            if (tx_ch_lz_i) begin
               msg_d   = tx_ch_z_i;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            wr_o   = 1'b1;
            busy_o = 1'b1;
            if (!wait_i) begin
               if (idx_q == LAST) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // a strobe while not ready is dropped; only the flag records it
      err_d = err_q | (tx_ch_lz_i & ~tx_ch_vz_o);
   end

   // zero-extend the message to a whole number of flits
   always_comb begin
      padded                     = '0;
      padded[RMI_MSG_SIZE-1:0]   = msg_q;
   end

   assign data = padded[int'(idx_q)*SIZE_DATA +: SIZE_DATA];
   assign dst  = msg_q[RMI_MSG_SIZE-1 -: HDR_W];

   // output is forced to zero outside SEND so reset clears it at once
   assign din_o = wr_o ? {dst, X, Y, LOCAL_ADDR, data} : '0;

   assign err_o     = err_q;
   assign msg_cnt_o = cnt_q;

endmodule

// File: tb/tb_achannel_to_rtsnoc_tx.sv
// Self-checking bench for achannel_to_rtsnoc_tx: vector table plus scoreboard
// of expected flits, popped as the router side accepts them.
module tb_achannel_to_rtsnoc_tx;

   typedef struct {
      logic [79:0] msg;
      logic [9:0]  hdr;
      logic [55:0] d0;
      logic [55:0] d1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [79:0] z = '0;
   logic        lz = 1'b0;
   logic        stall = 1'b0;
   logic        vz, wr, busy, err;
   logic [65:0] din;
   logic [15:0] cnt;

   logic        s_vz, s_wr, s_busy, s_err;
   logic [65:0] s_din;
   logic [1:0]  s_cnt;

   vec_t        tbl[4];
   logic [65:0] sb[$];
   logic        alt = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          xfers = 0;

   achannel_to_rtsnoc_tx dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .tx_ch_z_i(z), .tx_ch_lz_i(lz), .tx_ch_vz_o(vz),
      .din_o(din), .wr_o(wr), .wait_i(stall),
      .busy_o(busy), .err_o(err), .msg_cnt_o(cnt)
   );

   achannel_to_rtsnoc_tx #(.CNT_W(2)) dut_small (
      .clk_i(clk), .rst_n_i(rst_n),
      .tx_ch_z_i(z), .tx_ch_lz_i(lz), .tx_ch_vz_o(s_vz),
      .din_o(s_din), .wr_o(s_wr), .wait_i(stall),
      .busy_o(s_busy), .err_o(s_err), .msg_cnt_o(s_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // a flit is taken on the next rising edge when wr=1 and wait=0
   always @(negedge clk) begin
      if (rst_n && wr && !stall) begin
         xfers++;
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_flit: got %h expected none", din);
         end else begin
            chk("flit", din, sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (alt) stall = ~stall;
   endtask

   task automatic send(int v);
      int n = 0;
      while (!vz && n < 100) begin
         tick();
         n++;
      end
      chk("send_ready", {65'd0, vz}, 66'd1);
      z  = tbl[v].msg;
      lz = 1'b1;
      sb.push_back({tbl[v].hdr, tbl[v].d0});
      sb.push_back({tbl[v].hdr, tbl[v].d1});
      tick();
      lz = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!vz && n < 100) begin
         tick();
         n++;
      end
      chk("idle_timeout", {65'd0, vz}, 66'd1);
   endtask

   initial begin
      int x0;
      tbl[0] = '{80'h9800_0000_0000_0000_00AB, 10'b1001111101,
                 56'h000000000000AB, 56'h00000000980000};
      tbl[1] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 10'b1111111101,
                 56'hFFFFFFFFFFFFFF, 56'h00000000FFFFFF};
      tbl[2] = '{80'h0000_1234_5678_9ABC_DEF0, 10'b0000011101,
                 56'h3456789ABCDEF0, 56'h00000000000012};
      tbl[3] = '{80'h4123_4567_89AB_CDEF_0011, 10'b0100011101,
                 56'h6789ABCDEF0011, 56'h00000000412345};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_vz", {65'd0, vz}, 66'd1);
      chk("rst_wr", {65'd0, wr}, 66'd0);
      chk("rst_din", din, 66'd0);
      chk("rst_busy", {65'd0, busy}, 66'd0);
      chk("rst_err", {65'd0, err}, 66'd0);
      chk("rst_cnt", {50'd0, cnt}, 66'd0);
      tick();
      rst_n = 1'b1;

      // latency: strobe at t, flits at t+1 and t+2, ready at t+3
      z  = tbl[0].msg;
      lz = 1'b1;
      sb.push_back({tbl[0].hdr, tbl[0].d0});
      sb.push_back({tbl[0].hdr, tbl[0].d1});
      @(negedge clk);
      chk("cap_vz", {65'd0, vz}, 66'd1);
      chk("cap_wr", {65'd0, wr}, 66'd0);
      tick();
      lz = 1'b0;
      @(negedge clk);
      chk("f0_wr", {65'd0, wr}, 66'd1);
      chk("f0_busy", {65'd0, busy}, 66'd1);
      chk("f0_vz", {65'd0, vz}, 66'd0);
      chk("f0_top10", {56'd0, din[65:56]}, {56'd0, 10'b1001111101});
      tick();
      @(negedge clk);
      chk("f1_data", {10'd0, din[55:0]}, {10'd0, 56'h00000000980000});
      tick();
      @(negedge clk);
      chk("done_wr", {65'd0, wr}, 66'd0);
      chk("done_vz", {65'd0, vz}, 66'd1);
      chk("done_cnt", {50'd0, cnt}, 66'd1);

      // table of messages, back to back
      for (int i = 0; i < 4; i++) send(i);
      wait_idle();
      chk("tbl_cnt", {50'd0, cnt}, 66'd5);
      chk("tbl_err", {65'd0, err}, 66'd0);

      // flit 0 held under 5 cycles of back-pressure
      tick();
      z     = tbl[0].msg;
      lz    = 1'b1;
      stall = 1'b1;
      sb.push_back({tbl[0].hdr, tbl[0].d0});
      sb.push_back({tbl[0].hdr, tbl[0].d1});
      tick();
      lz = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_wr", {65'd0, wr}, 66'd1);
         chk("stall_din", din, {tbl[0].hdr, tbl[0].d0});
         tick();
      end
      stall = 1'b0;
      @(negedge clk);
      chk("stall_last", din, {tbl[0].hdr, tbl[0].d0});
      tick();
      @(negedge clk);
      chk("stall_f1", din, {tbl[0].hdr, tbl[0].d1});
      tick();
      @(negedge clk);
      chk("stall_vz", {65'd0, vz}, 66'd1);
      chk("stall_cnt", {50'd0, cnt}, 66'd6);

      // alternating back-pressure over 3 messages
      x0  = xfers;
      alt = 1'b1;
      send(1);
      send(2);
      send(3);
      wait_idle();
      alt   = 1'b0;
      stall = 1'b0;
      chk("alt_xfers", 66'(xfers - x0), 66'd6);
      chk("alt_cnt", {50'd0, cnt}, 66'd9);

      // strobe while busy is dropped and flagged
      send(1);
      z  = tbl[2].msg;
      lz = 1'b1;
      tick();
      lz = 1'b0;
      @(negedge clk);
      chk("err_set", {65'd0, err}, 66'd1);
      wait_idle();
      tick();
      tick();
      chk("err_sticky", {65'd0, err}, 66'd1);
      chk("err_cnt", {50'd0, cnt}, 66'd10);
      chk("err_busy", {65'd0, busy}, 66'd0);

      // reset after flit 0
      send(3);
      tick();
      stall = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mrst_wr", {65'd0, wr}, 66'd0);
      chk("mrst_vz", {65'd0, vz}, 66'd1);
      chk("mrst_cnt", {50'd0, cnt}, 66'd0);
      chk("mrst_err", {65'd0, err}, 66'd0);
      chk("mrst_din", din, 66'd0);
      chk("mrst_q", 66'(sb.size()), 66'd1);
      sb.delete();
      tick();
      rst_n = 1'b1;
      stall = 1'b0;
      tick();

      // counter wrap on a 2-bit counter instance
      for (int i = 0; i < 3; i++) send(i);
      wait_idle();
      chk("wrap_pre", {64'd0, s_cnt}, 66'd3);
      send(0);
      wait_idle();
      chk("wrap_zero", {64'd0, s_cnt}, 66'd0);
      chk("wrap_big", {50'd0, cnt}, 66'd4);
      chk("wrap_err", {65'd0, s_err}, 66'd0);

      tick();
      chk("sb_empty", 66'(sb.size()), 66'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
